decode: RTL and testbench
=========================

// Module: decode
// PURPOSE
//  RV32I decode stage between instruction fetch and execute. Accepts one
//  instruction and its address per cycle over a valid/ready handshake and
//  splits it into register indices, a sign-extended immediate and an operation
//  class. Drives synchronous-read register-file addresses so operand data
//  arrives together with the registered decode result. Flushed by jmp.
// PARAMETERS
//  RESET_ADDR   32'h0   reset value of out_pc
//  CHECK_ILLEGAL 1      1: reject reserved encodings (op=ILLEGAL); 0: only opcode checked
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst_n      in   1   asynchronous active-low reset
//  in_instr   in   32  instruction word from fetch (instr)
//  in_addr    in   32  instruction address from fetch (instr_addr)
//  in_valid   in   1   fetch has an instruction (valid)
//  in_ready   out  1   stage accepts this cycle (ready to fetch)
//  jmp        in   1   flush from execute, same signal fetch receives
//  rf_ra1     out  5   regfile read address 1 (regfile registers it)
//  rf_ra2     out  5   regfile read address 2
//  out_valid  out  1   decoded instruction held
//  out_ready  in   1   execute consumes
//  out_pc     out  32  instruction address
//  out_op     out  4   class: 0 LUI 1 AUIPC 2 JAL 3 JALR 4 BRANCH 5 LOAD 6 STORE
//                      7 ALUI 8 ALU 9 FENCE 10 SYSTEM 15 ILLEGAL
//  out_rd/out_rs1/out_rs2  out 5 each   instr[11:7]/[19:15]/[24:20]; rd=0 for BRANCH/STORE
//  out_funct3 out  3   instr[14:12];  out_alt  out 1  instr[30]
//  out_imm    out  32  sign-extended immediate per format; 0 for ALU/FENCE/ILLEGAL
//  out_instr  out  32  raw word (SYSTEM/CSR use, debug)
// BEHAVIOUR
//  - Reset: out_valid=0, out_pc=RESET_ADDR, all other out_* = 0, out_op=15.
//  - in_ready = !out_valid || out_ready (combinational, never depends on in_valid).
//  - accept = in_valid && in_ready && !jmp: next edge registers decode of in_instr,
//    out_valid<=1. Latency 1 cycle; full throughput with out_ready held high.
//  - out_valid && out_ready && !accept: out_valid<=0. Outputs hold while
//    out_valid && !out_ready (stall); no change on any out_* during stall.
//  - jmp: out_valid<=0 next edge, input word of that cycle discarded, overrides
//    accept and consume; other out_* may keep stale values.
//  - rf_ra1/rf_ra2 = in_ready ? in_instr[19:15]/[24:20] : out_rs1/out_rs2, so
//    registered regfile data always matches the held instruction (also after stall).
//  - Immediates: I={{20{i[31]}},i[31:20]}; S={{20{i[31]}},i[31:25],i[11:7]};
//    B={{19{i[31]}},i[31],i[7],i[30:25],i[11:8],0}; U={i[31:12],12'h0};
//    J={{11{i[31]}},i[31],i[19:12],i[20],i[30:21],0}. JALR/LOAD/ALUI/SYSTEM use I.
//  - ILLEGAL when i[1:0]!=2'b11 or opcode unknown; with CHECK_ILLEGAL also:
//    JALR f3!=0; BRANCH f3 in {2,3}; LOAD f3 in {3,6,7}; STORE f3>2;
//    ALU f7 not 0x00/0x20, or 0x20 with f3 not 0/5; ALUI f3=1 f7!=0, f3=5 f7 not 0/0x20.
//    ILLEGAL still flows with out_valid=1; execute raises the trap.
//  - rst_n low mid-stall: out_valid drops immediately (async), in_ready=1.
// TESTING
//  1 reset, in 0x00500093 -> next edge op=7 rd=1 rs1=0 imm=5 out_pc=in_addr
//  2 0xFFF00113 / 0x0020A223 / 0xFE000EE3 / 0x008000EF / 0x123452B7 -> imm
//    FFFFFFFF / 4 (rs1=1 rs2=2 rd=0) / FFFFFFFC / 8 (op=2 rd=1) / 12345000
//  3 out_ready=0 for 3 cycles with new in_valid -> in_ready=0, outputs and
//    rf_ra1/2 frozen; release -> next word accepted that edge, no loss/duplicate
//  4 jmp with in_valid=1 and out_valid=1 -> out_valid=0 next cycle, word dropped
//  5 0x00000000, 0xFFFFFFFF, 0x4000F0B3 (sub with f3=7) -> op=15, imm=0
//  6 stream 100 random legal words, out_ready random -> order and fields match model

Source files
------------

// File: rtl/decode.sv
// RV32I decode stage: one instruction per cycle over valid/ready, registered
// decode result, regfile read addresses steered so operand data lines up with
// the held instruction. A jmp flush empties the stage.
module decode #(
  parameter logic [31:0] RESET_ADDR    = 32'h0,
  parameter bit          CHECK_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        jmp,
  output logic [4:0]  rf_ra1,
  output logic [4:0]  rf_ra2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [3:0]  out_op,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic        out_alt,
  output logic [31:0] out_imm,
  output logic [31:0] out_instr
);

  localparam logic [3:0] OpLui     = 4'd0;
  localparam logic [3:0] OpAuipc   = 4'd1;
  localparam logic [3:0] OpJal     = 4'd2;
  localparam logic [3:0] OpJalr    = 4'd3;
  localparam logic [3:0] OpBranch  = 4'd4;
  localparam logic [3:0] OpLoad    = 4'd5;
  localparam logic [3:0] OpStore   = 4'd6;
  localparam logic [3:0] OpAluI    = 4'd7;
  localparam logic [3:0] OpAlu     = 4'd8;
  localparam logic [3:0] OpFence   = 4'd9;
  localparam logic [3:0] OpSystem  = 4'd10;
  localparam logic [3:0] OpIllegal = 4'd15;

  logic        valid_q, valid_d;
  logic [31:0] pc_q, imm_q, instr_q, imm_d;
  logic [3:0]  op_q, op_d;
  logic [4:0]  rd_q, rs1_q, rs2_q, rd_d;
  logic [2:0]  funct3_q;
  logic        alt_q;
  logic        accept, bad;

  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                  in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'h000};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                  in_instr[30:21], 1'b0};

  // in_ready is independent of in_valid so fetch can use it without a loop
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !jmp;

  // While stalled, keep addressing the held instruction's sources so the
  // regfile's registered read keeps returning matching operands.
  assign rf_ra1 = in_ready ? in_instr[19:15] : rs1_q;
  assign rf_ra2 = in_ready ? in_instr[24:20] : rs2_q;

  // Classify the incoming word and select its immediate
  always_comb begin
    op_d  = OpIllegal;
    imm_d = '0;
    bad   = 1'b0;
    if (in_instr[1:0] == 2'b11) begin
      case (in_instr[6:2])
        5'b01101: begin op_d = OpLui;    imm_d = imm_u; end
        5'b00101: begin op_d = OpAuipc;  imm_d = imm_u; end
        5'b11011: begin op_d = OpJal;    imm_d = imm_j; end
        5'b11001: begin op_d = OpJalr;   imm_d = imm_i; bad = (f3 != 3'd0); end
        5'b11000: begin
          op_d  = OpBranch;
          imm_d = imm_b;
          bad   = (f3 == 3'd2) || (f3 == 3'd3);
        end
        5'b00000: begin
          op_d  = OpLoad;
          imm_d = imm_i;
          bad   = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        end
        5'b01000: begin op_d = OpStore;  imm_d = imm_s; bad = (f3 > 3'd2); end
        5'b00100: begin
          op_d  = OpAluI;
          imm_d = imm_i;
          bad   = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                  ((f3 == 3'd5) && (f7 != 7'h00) && (f7 != 7'h20));
        end
        5'b01100: begin
          op_d = OpAlu;
          bad  = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
        end
        5'b00011: op_d = OpFence;
        5'b11100: begin op_d = OpSystem; imm_d = imm_i; end
        default:  op_d = OpIllegal;
      endcase
    end
    if (CHECK_ILLEGAL && bad) op_d = OpIllegal;
    if (op_d == OpIllegal) imm_d = '0;
    rd_d = ((op_d == OpBranch) || (op_d == OpStore)) ? 5'd0 : in_instr[11:7];
  end

  // Occupancy: flush wins, then accept, then consume
  always_comb begin
    valid_d = valid_q;
    if (jmp)                       valid_d = 1'b0;
    else if (accept)               valid_d = 1'b1;
    else if (valid_q && out_ready) valid_d = 1'b0;
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= 1'b0;
    else        valid_q <= valid_d;
  end

  // Decoded payload, loaded only on accept so it holds through stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_ADDR;
      op_q     <= OpIllegal;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      alt_q    <= 1'b0;
      imm_q    <= '0;
      instr_q  <= '0;
    end else if (accept) begin
      pc_q     <= in_addr;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs1_q    <= in_instr[19:15];
      rs2_q    <= in_instr[24:20];
      funct3_q <= f3;
      alt_q    <= in_instr[30];
      imm_q    <= imm_d;
      instr_q  <= in_instr;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_op     = op_q;
  assign out_rd     = rd_q;
  assign out_rs1    = rs1_q;
  assign out_rs2    = rs2_q;
  assign out_funct3 = funct3_q;
  assign out_alt    = alt_q;
  assign out_imm    = imm_q;
  assign out_instr  = instr_q;

endmodule

// File: tb/tb_decode.sv
// Bench for the decode stage: directed vector table, stall / flush / async
// reset sequences, and a random stream checked against a reference model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_instr, in_addr;
  logic        in_valid, in_ready, jmp;
  logic [4:0]  rf_ra1, rf_ra2;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_imm, out_instr;
  logic [3:0]  out_op;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic        out_alt;

  always #5 clk = ~clk;

  decode #(
    .RESET_ADDR   (32'h0),
    .CHECK_ILLEGAL(1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_instr  (in_instr),
    .in_addr   (in_addr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .jmp       (jmp),
    .rf_ra1    (rf_ra1),
    .rf_ra2    (rf_ra2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_op    (out_op),
    .out_rd    (out_rd),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2),
    .out_funct3(out_funct3),
    .out_alt   (out_alt),
    .out_imm   (out_imm),
    .out_instr (out_instr)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic        alt;
    logic [31:0] imm;
  } dec_t;

  typedef struct packed {
    logic [31:0] instr;
    dec_t        d;
  } vec_t;

  typedef struct packed {
    dec_t        d;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference decoder written from the ISA tables
  function automatic dec_t model(input logic [31:0] i);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    f3    = i[14:12];
    f7    = i[31:25];
    ok    = 1'b1;
    d.rd  = i[11:7];
    d.rs1 = i[19:15];
    d.rs2 = i[24:20];
    d.f3  = f3;
    d.alt = i[30];
    d.op  = 4'd15;
    d.imm = 32'h0;
    if (i[1:0] == 2'b11) begin
      case (i[6:0])
        7'h37: begin d.op = 4'd0; d.imm = {i[31:12], 12'h0}; end
        7'h17: begin d.op = 4'd1; d.imm = {i[31:12], 12'h0}; end
        7'h6F: begin
          d.op  = 4'd2;
          d.imm = {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
        end
        7'h67: begin d.op = 4'd3; d.imm = {{20{i[31]}}, i[31:20]}; ok = (f3 == 0); end
        7'h63: begin
          d.op  = 4'd4;
          d.imm = {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
          ok    = (f3 != 2) && (f3 != 3);
        end
        7'h03: begin
          d.op  = 4'd5;
          d.imm = {{20{i[31]}}, i[31:20]};
          ok    = (f3 <= 2) || (f3 == 4) || (f3 == 5);
        end
        7'h23: begin d.op = 4'd6; d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; ok = (f3 <= 2); end
        7'h13: begin
          d.op  = 4'd7;
          d.imm = {{20{i[31]}}, i[31:20]};
          if (f3 == 1) ok = (f7 == 0);
          if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
        end
        7'h33: begin
          d.op = 4'd8;
          case (f7)
            7'h00:   ok = 1'b1;
            7'h20:   ok = (f3 == 0) || (f3 == 5);
            default: ok = 1'b0;
          endcase
        end
        7'h0F: d.op = 4'd9;
        7'h73: begin d.op = 4'd10; d.imm = {{20{i[31]}}, i[31:20]}; end
        default: d.op = 4'd15;
      endcase
    end
    if (!ok) d.op = 4'd15;
    if (d.op == 4'd15) d.imm = 32'h0;
    if (d.op == 4'd4 || d.op == 4'd6) d.rd = 5'd0;
    return d;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [6:0]  opcs [11];
    logic [31:0] w;
    dec_t        d;
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    do begin
      w      = $urandom;
      w[6:0] = opcs[$urandom_range(0, 10)];
      d      = model(w);
    end while (d.op == 4'd15);
    return w;
  endfunction

  task automatic chk_out(input string nm, input dec_t e, input logic [31:0] pc,
                         input logic [31:0] ins);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_op"}, out_op, e.op);
    chk({nm, "_rd"}, out_rd, e.rd);
    chk({nm, "_rs1"}, out_rs1, e.rs1);
    chk({nm, "_rs2"}, out_rs2, e.rs2);
    chk({nm, "_f3"}, out_funct3, e.f3);
    chk({nm, "_alt"}, out_alt, e.alt);
    chk({nm, "_imm"}, out_imm, e.imm);
    chk({nm, "_pc"}, out_pc, pc);
    chk({nm, "_instr"}, out_instr, ins);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [20];
  exp_t q[$];
  exp_t e;
  int   sent, got, cyc;

  initial begin
    //          instr         op     rd     rs1    rs2    f3    alt   imm
    vecs[0]  = {32'h00500093, 4'd7,  5'd1,  5'd0,  5'd5,  3'd0, 1'b0, 32'h00000005};
    vecs[1]  = {32'hFFF00113, 4'd7,  5'd2,  5'd0,  5'd31, 3'd0, 1'b1, 32'hFFFFFFFF};
    vecs[2]  = {32'h0020A223, 4'd6,  5'd0,  5'd1,  5'd2,  3'd2, 1'b0, 32'h00000004};
    vecs[3]  = {32'hFE000EE3, 4'd4,  5'd0,  5'd0,  5'd0,  3'd0, 1'b1, 32'hFFFFFFFC};
    vecs[4]  = {32'h008000EF, 4'd2,  5'd1,  5'd0,  5'd8,  3'd0, 1'b0, 32'h00000008};
    vecs[5]  = {32'h123452B7, 4'd0,  5'd5,  5'd8,  5'd3,  3'd5, 1'b0, 32'h12345000};
    vecs[6]  = {32'h00000000, 4'd15, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000};
    vecs[7]  = {32'hFFFFFFFF, 4'd15, 5'd31, 5'd31, 5'd31, 3'd7, 1'b1, 32'h00000000};
    vecs[8]  = {32'h4000F0B3, 4'd15, 5'd1,  5'd1,  5'd0,  3'd7, 1'b1, 32'h00000000};
    vecs[9]  = {32'h402081B3, 4'd8,  5'd3,  5'd1,  5'd2,  3'd0, 1'b1, 32'h00000000};
    vecs[10] = {32'hFFFFF397, 4'd1,  5'd7,  5'd31, 5'd31, 3'd7, 1'b1, 32'hFFFFF000};
    vecs[11] = {32'hFF812303, 4'd5,  5'd6,  5'd2,  5'd24, 3'd2, 1'b1, 32'hFFFFFFF8};
    vecs[12] = {32'h000280E7, 4'd3,  5'd1,  5'd5,  5'd0,  3'd0, 1'b0, 32'h00000000};
    vecs[13] = {32'h000290E7, 4'd15, 5'd1,  5'd5,  5'd0,  3'd1, 1'b0, 32'h00000000};
    vecs[14] = {32'h00000073, 4'd10, 5'd0,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000};
    vecs[15] = {32'h00100073, 4'd10, 5'd0,  5'd0,  5'd1,  3'd0, 1'b0, 32'h00000001};
    vecs[16] = {32'h0FF0000F, 4'd9,  5'd0,  5'd0,  5'd31, 3'd0, 1'b0, 32'h00000000};
    vecs[17] = {32'h40315093, 4'd7,  5'd1,  5'd2,  5'd3,  3'd5, 1'b1, 32'h00000403};
    vecs[18] = {32'h40311093, 4'd15, 5'd1,  5'd2,  5'd3,  3'd1, 1'b1, 32'h00000000};
    vecs[19] = {32'h00000093, 4'd7,  5'd1,  5'd0,  5'd0,  3'd0, 1'b0, 32'h00000000};

    in_instr  = '0;
    in_addr   = '0;
    in_valid  = 1'b0;
    jmp       = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #12;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_op", out_op, 4'd15);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_rd", out_rd, 5'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;

    // Directed vectors, one per cycle at full throughput
    for (int k = 0; k < 20; k++) begin
      in_instr  = vecs[k].instr;
      in_addr   = 32'h1000 + 32'(k * 4);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      #1;
      chk($sformatf("v%0d_ra1", k), rf_ra1, vecs[k].instr[19:15]);
      chk($sformatf("v%0d_ra2", k), rf_ra2, vecs[k].instr[24:20]);
      @(posedge clk);
      #1;
      chk_out($sformatf("v%0d", k), vecs[k].d, 32'h1000 + 32'(k * 4), vecs[k].instr);
    end

    // Stall: B waits three cycles behind held A, then goes through exactly once
    in_instr = 32'h402081B3; in_addr = 32'h2000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_instr  = 32'hFF812303;
    in_addr   = 32'h2004;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d_in_ready", c), in_ready, 1'b0);
      chk($sformatf("stall%0d_ra1", c), rf_ra1, 5'd1);
      chk($sformatf("stall%0d_ra2", c), rf_ra2, 5'd2);
      tick();
      chk_out($sformatf("stall%0d", c), model(32'h402081B3), 32'h2000, 32'h402081B3);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_ra1", rf_ra1, 5'd2);
    tick();
    chk_out("release", model(32'hFF812303), 32'h2004, 32'hFF812303);
    in_valid = 1'b0;
    tick();
    chk("drain_valid", out_valid, 1'b0);

    // Flush while full with a new word offered
    in_instr = 32'h00500093; in_addr = 32'h3000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    chk("pre_jmp_valid", out_valid, 1'b1);
    in_instr = 32'hFFF00113; in_addr = 32'h3004; jmp = 1'b1; out_ready = 1'b0;
    tick();
    chk("jmp_valid", out_valid, 1'b0);
    jmp = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("jmp_dropped", out_valid, 1'b0);
    chk("jmp_pc_not_loaded", out_pc, 32'h3000);

    // Asynchronous reset in the middle of a stall
    in_instr = 32'h123452B7; in_addr = 32'h4000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_op", out_op, 4'd15);
    chk("arst_pc", out_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Random legal stream with random backpressure
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 100 && cyc < 3000) begin
      if (sent < 100 && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_instr = rand_legal();
        in_addr  = $urandom & 32'hFFFF_FFFC;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #3;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_extra: got unexpected output instr %0h expected none", out_instr);
        end else begin
          e = q.pop_front();
          chk($sformatf("stream%0d", got),
              {out_op, out_rd, out_rs1, out_rs2, out_funct3, out_alt, out_imm, out_pc, out_instr},
              e);
          got++;
        end
      end
      if (in_valid && in_ready && !jmp) begin
        q.push_back({model(in_instr), in_addr, in_instr});
        sent++;
      end
      tick();
      cyc++;
    end
    chk("stream_count", got, 100);
    chk("stream_leftover", q.size(), 0);
    in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
